branch_resolve_unit: RTL

Parametrised multi-slot successor to the single-lane branch executor. It resolves up to N_SLOTS branch/jump operations from one VLIW bundle in parallel and selects the architecturally first taken slot. It compares the outcome against the fetch prediction and drives a registered redirect and link write-back toward fetch and the register file. It sits as one pipeline stage between operand read and write-back, with valid/ready handshakes on both sides.

---
 rtl/branch_resolve_unit.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : Resolves up to N_SLOTS branch/jump operations of one VLIW
//               bundle in parallel. It selects the lowest-index taken slot,
//               compares the resulting next PC against the fetch prediction,
//               and registers the redirect and link write-back. It forms one
//               valid/ready pipeline stage.
//               Optional feature macro: BRANCH_STATS_EN (resolve and
//               mispredict counters).
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int XLEN         = 32,
    parameter int N_SLOTS      = 2,
    parameter int BR_IMM_W     = 12,
    parameter int JMP_IMM_W    = 22,
    parameter int BUNDLE_BYTES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [XLEN-1:0]               in_pc,
    input  logic [XLEN-1:0]               in_pred_pc,
    input  logic [N_SLOTS-1:0]            slot_valid,
    input  logic [N_SLOTS-1:0]            slot_is_jmp,
    input  logic [N_SLOTS-1:0]            slot_is_reg,
    input  logic [N_SLOTS-1:0]            slot_zero_ext,
    input  logic [2*N_SLOTS-1:0]          slot_op,
    input  logic [N_SLOTS*XLEN-1:0]       slot_rs1,
    input  logic [N_SLOTS*XLEN-1:0]       slot_rs2,
    input  logic [N_SLOTS*JMP_IMM_W-1:0]  slot_imm,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          redirect,
    output logic [XLEN-1:0]               redirect_pc,
    output logic [$clog2(N_SLOTS):0]      taken_slot,
    output logic [N_SLOTS-1:0]            link_wr_en,
`ifdef BRANCH_STATS_EN
    input  logic                          stat_clr,
    output logic [31:0]                   stat_resolved,
    output logic [31:0]                   stat_mispredict,
`endif
    output logic [XLEN-1:0]               link_data
);

    localparam int              c_TAKEN_W    = $clog2(N_SLOTS) + 1;
    localparam logic [XLEN-1:0] c_BUNDLE_INC = XLEN'(BUNDLE_BYTES);
    localparam logic [XLEN-1:0] c_CLR_BIT0   = ~{{(XLEN-1){1'b0}}, 1'b1};

    logic [N_SLOTS-1:0]      w_taken;
    logic [N_SLOTS-1:0]      w_link_cand;
    logic [N_SLOTS*XLEN-1:0] w_target_flat;
    logic [XLEN-1:0]         w_seq_pc;
    logic                    w_found;
    logic [c_TAKEN_W-1:0]    w_win;
    logic [XLEN-1:0]         w_actual;
    logic [N_SLOTS-1:0]      w_link;
    logic                    w_load;

    logic                    r_out_valid;
    logic                    r_redirect;
    logic [XLEN-1:0]         r_redirect_pc;
    logic [c_TAKEN_W-1:0]    r_taken_slot;
    logic [N_SLOTS-1:0]      r_link_wr_en;
    logic [XLEN-1:0]         r_link_data;

    assign w_seq_pc = in_pc + c_BUNDLE_INC;

    // Per-slot condition evaluation and target generation
    for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
        logic [XLEN-1:0]      w_rs1;
        logic [XLEN-1:0]      w_rs2;
        logic [JMP_IMM_W-1:0] w_imm;
        logic [1:0]           w_op;
        logic [XLEN-1:0]      w_br_off;
        logic [XLEN-1:0]      w_jmp_off;
        logic [XLEN-1:0]      w_reg_tgt;
        logic                 w_eq;
        logic                 w_lt;
        logic                 w_cond;

        assign w_rs1     = slot_rs1[g*XLEN +: XLEN];
        assign w_rs2     = slot_rs2[g*XLEN +: XLEN];
        assign w_imm     = slot_imm[g*JMP_IMM_W +: JMP_IMM_W];
        assign w_op      = slot_op[2*g +: 2];
        // Branches and register jumps only use the short immediate field
        assign w_br_off  = {{(XLEN-BR_IMM_W){w_imm[BR_IMM_W-1]}}, w_imm[BR_IMM_W-1:0]};
        assign w_jmp_off = {{(XLEN-JMP_IMM_W){w_imm[JMP_IMM_W-1]}}, w_imm};
        assign w_reg_tgt = (w_rs1 + w_br_off) & c_CLR_BIT0;

        assign w_eq   = (w_rs1 == w_rs2);
        assign w_lt   = slot_zero_ext[g] ? (w_rs1 < w_rs2)
                                         : ($signed(w_rs1) < $signed(w_rs2));
        assign w_cond = (w_op == 2'd0) ? w_eq  :
                        (w_op == 2'd1) ? ~w_eq :
                        (w_op == 2'd2) ? w_lt  : ~w_lt;

        assign w_taken[g]     = slot_valid[g] & (slot_is_jmp[g] | w_cond);
        assign w_link_cand[g] = slot_valid[g] & slot_is_jmp[g] & slot_is_reg[g];

        assign w_target_flat[g*XLEN +: XLEN] =
            !slot_is_jmp[g] ? (in_pc + w_br_off) :
            slot_is_reg[g]  ? w_reg_tgt          :
                              (in_pc + w_jmp_off);
    end

    // Lowest-index taken slot wins; link writes of younger slots are squashed
    always_comb begin
        w_found  = 1'b0;
        w_win    = c_TAKEN_W'(N_SLOTS);
        w_actual = w_seq_pc;
        w_link   = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            w_link[i] = w_link_cand[i] & ~w_found;
            if (!w_found && w_taken[i]) begin
                w_found  = 1'b1;
                w_win    = c_TAKEN_W'(i);
                w_actual = w_target_flat[i*XLEN +: XLEN];
            end
        end
    end

    assign in_ready = !r_out_valid || out_ready;
    assign w_load   = in_valid && in_ready;

    // Output stage register: flush beats load, results hold while stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_taken_slot  <= c_TAKEN_W'(N_SLOTS);
            r_link_wr_en  <= '0;
            r_link_data   <= '0;
        end else if (flush) begin
            r_out_valid   <= 1'b0;
        end else if (w_load) begin
            r_out_valid   <= 1'b1;
            r_redirect    <= (w_actual != in_pred_pc);
            r_redirect_pc <= w_actual;
            r_taken_slot  <= w_win;
            r_link_wr_en  <= w_link;
            r_link_data   <= w_seq_pc;
        end else if (out_ready) begin
            r_out_valid   <= 1'b0;
        end
    end

    assign out_valid   = r_out_valid;
    assign redirect    = r_redirect;
    assign redirect_pc = r_redirect_pc;
    assign taken_slot  = r_taken_slot;
    assign link_wr_en  = r_link_wr_en;
    assign link_data   = r_link_data;

`ifdef BRANCH_STATS_EN
    logic        r_any_valid;
    logic [31:0] r_stat_resolved;
    logic [31:0] r_stat_mispredict;
    logic        w_out_hs;

    assign w_out_hs = r_out_valid && out_ready;

    // Remember whether the held bundle contained any branch/jump at all
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_any_valid <= 1'b0;
        end else if (w_load) begin
            r_any_valid <= |slot_valid;
        end
    end

    // Saturating event counters; clear beats a same-cycle increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_resolved   <= '0;
            r_stat_mispredict <= '0;
        end else if (stat_clr) begin
            r_stat_resolved   <= '0;
            r_stat_mispredict <= '0;
        end else if (w_out_hs && r_any_valid) begin
            if (r_stat_resolved != 32'hFFFF_FFFF) begin
                r_stat_resolved <= r_stat_resolved + 32'd1;
            end
            if (r_redirect && (r_stat_mispredict != 32'hFFFF_FFFF)) begin
                r_stat_mispredict <= r_stat_mispredict + 32'd1;
            end
        end
    end

    assign stat_resolved   = r_stat_resolved;
    assign stat_mispredict = r_stat_mispredict;
`endif

endmodule
`default_nettype wire
